serial_word_arbiter: RTL and testbench

//  Round-robin scheduler that shares the single 19-bit serial link (3-bit addr + 16-bit data) between N_REQ requesters.

---
 rtl/serial_word_arbiter_pkg.sv | 16 +
 rtl/serial_word_arbiter_if.sv | 32 +++
 rtl/serial_word_arbiter_rr_pick.sv | 25 ++
 rtl/serial_word_arbiter.sv | 151 +++++++++++++++
 tb/tb_serial_word_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_arbiter_pkg.sv
// Shared types for the serial word arbiter: FSM states and link field widths.
// Optional timeout supervision is enabled with SER_ARB_TIMEOUT_EN.
package ser_arb_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE,
        ACKN
    } state_t;

endpackage

// File: rtl/serial_word_arbiter_if.sv
// Requester/serializer bundle around the serial word arbiter.
// Optional timeout supervision is enabled with SER_ARB_TIMEOUT_EN.
interface serial_word_arbiter_if #(
    parameter int N_REQ = 4
);
    import ser_arb_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [ADDR_W-1:0]       ser_addr;
    logic [DATA_W-1:0]       ser_data;
    logic                    ser_ena;
    logic                    ser_busy;
    logic [ID_W-1:0]         grant_id;
    logic                    active;
    logic                    err;

    modport master (
        output req, req_addr, req_data, ser_busy,
        input  ack, ser_addr, ser_data, ser_ena, grant_id, active, err
    );

    modport slave (
        input  req, req_addr, req_data, ser_busy,
        output ack, ser_addr, ser_data, ser_ena, grant_id, active, err
    );

endinterface

// File: rtl/serial_word_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr.
// Used by serial_word_arbiter (SER_ARB_TIMEOUT_EN has no effect here).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    assign valid = |req;

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ID_W'((int'(ptr) + k) % N_REQ)]) begin
                idx = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/serial_word_arbiter.sv
// Round-robin arbiter sharing one serial word link among N_REQ requesters.
// Define SER_ARB_TIMEOUT_EN to add start/done timeouts with a sticky err flag.
module serial_word_arbiter
    import ser_arb_pkg::*;
#(
    parameter int N_REQ    = 4
`ifdef SER_ARB_TIMEOUT_EN
    ,
    parameter int START_TO = 4,
    parameter int DONE_TO  = 31
`endif
) (
    input logic                 clk,
    input logic                 rst,
    serial_word_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(N_REQ);

    state_t              state, state_n;
    logic [ID_W-1:0]     ptr, ptr_n;
    logic [ID_W-1:0]     gid, gid_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   data_q, data_n;
    logic                act, act_n;
    logic                pick_valid;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     gid_inc;

`ifdef SER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(DONE_TO + 1);
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                err_q, err_n;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign gid_inc = (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gid_n   = gid;
        addr_n  = addr_q;
        data_n  = data_q;
        act_n   = act;
`ifdef SER_ARB_TIMEOUT_EN
        cnt_n   = cnt;
        err_n   = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (pick_valid && !bus.ser_busy) begin
                    gid_n   = pick_idx;
                    addr_n  = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
                    data_n  = bus.req_data[pick_idx*DATA_W +: DATA_W];
                    act_n   = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                state_n = WAIT_START;
`ifdef SER_ARB_TIMEOUT_EN
                cnt_n   = '0;
`endif
            end
            WAIT_START: begin
                if (bus.ser_busy) begin
                    state_n = WAIT_DONE;
`ifdef SER_ARB_TIMEOUT_EN
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(START_TO - 1)) begin
                    err_n   = 1'b1;
                    act_n   = 1'b0;
                    ptr_n   = gid_inc;
                    state_n = IDLE;
                end else begin
                    cnt_n   = cnt + 1'b1;
`endif
                end
            end
            WAIT_DONE: begin
                if (!bus.ser_busy) begin
                    state_n = ACKN;
`ifdef SER_ARB_TIMEOUT_EN
                end else if (cnt == CNT_W'(DONE_TO - 1)) begin
                    err_n   = 1'b1;
                    act_n   = 1'b0;
                    ptr_n   = gid_inc;
                    state_n = IDLE;
                end else begin
                    cnt_n   = cnt + 1'b1;
`endif
                end
            end
            ACKN: begin
                ptr_n   = gid_inc;
                act_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            gid    <= '0;
            addr_q <= '0;
            data_q <= '0;
            act    <= 1'b0;
`ifdef SER_ARB_TIMEOUT_EN
            cnt    <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gid    <= gid_n;
            addr_q <= addr_n;
            data_q <= data_n;
            act    <= act_n;
`ifdef SER_ARB_TIMEOUT_EN
            cnt    <= cnt_n;
            err_q  <= err_n;
`endif
        end
    end

    assign bus.ser_ena  = (state == LOAD);
    assign bus.ack      = {N_REQ{state == ACKN}} & (N_REQ'(1) << gid);
    assign bus.ser_addr = addr_q;
    assign bus.ser_data = data_q;
    assign bus.grant_id = gid;
    assign bus.active   = act;
`ifdef SER_ARB_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_arbiter.sv
// Self-checking bench for serial_word_arbiter with a behavioural serializer.
// Timeout cases run only when SER_ARB_TIMEOUT_EN is defined.
module tb_serial_word_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_word_arbiter_if #(.N_REQ(4)) bus ();

    serial_word_arbiter #(.N_REQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Serializer model: busy for ser_len cycles starting the cycle after ena.
    int ser_len    = 4;
    bit ser_stuck  = 1'b0;
    bit force_busy = 1'b0;
    int busy_cnt   = 0;

    always @(posedge clk) begin
        if (rst)
            busy_cnt <= 0;
        else if (bus.ser_ena && !ser_stuck)
            busy_cnt <= ser_len;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end

    assign bus.ser_busy = (busy_cnt != 0) || force_busy;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic set_slot(input int i, input logic [2:0] a,
                            input logic [15:0] d);
        bus.req_addr[i*3 +: 3]   = a;
        bus.req_data[i*16 +: 16] = d;
    endtask

    // Apply mask (called at a negedge) and observe until ack or budget.
    task automatic xfer(input logic [3:0] mask, input int len,
                        output logic [1:0] g, output logic [2:0] a,
                        output logic [15:0] d, output logic [3:0] k,
                        output int lat, output logic act_ok);
        int t_ena;
        ser_len = len;
        bus.req = mask;
        g = '0; a = '0; d = '0; k = '0; lat = -1; act_ok = 1'b0;
        t_ena = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.ser_ena) begin
                t_ena = c;
                g = bus.grant_id;
                a = bus.ser_addr;
                d = bus.ser_data;
            end
            if (bus.ack != 0) begin
                k = bus.ack;
                lat = c - t_ena;
                act_ok = bus.active;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [1:0]  gid;
        logic [2:0]  addr;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[13];

    logic [1:0]  g;
    logic [2:0]  a;
    logic [15:0] d;
    logic [3:0]  k;
    int          lat;
    logic        ak;

    initial begin
        int m_ptr;
        int w;
        bit flag;
        logic [3:0]  mask;
        logic [2:0]  ra[4];
        logic [15:0] rd[4];

        tbl[0]  = '{4'b0010, 2'd1, 3'h5, 16'hA5C3};
        tbl[1]  = '{4'b1111, 2'd2, 3'h1, 16'h1234};
        tbl[2]  = '{4'b1111, 2'd3, 3'h7, 16'hFFFF};
        tbl[3]  = '{4'b1111, 2'd0, 3'h2, 16'h0000};
        tbl[4]  = '{4'b1111, 2'd1, 3'h3, 16'hBEEF};
        tbl[5]  = '{4'b0001, 2'd0, 3'h4, 16'h8001};
        tbl[6]  = '{4'b1001, 2'd3, 3'h6, 16'h7FFE};
        tbl[7]  = '{4'b1001, 2'd0, 3'h0, 16'h5555};
        tbl[8]  = '{4'b0110, 2'd1, 3'h1, 16'hAAAA};
        tbl[9]  = '{4'b1000, 2'd3, 3'h2, 16'h0F0F};
        tbl[10] = '{4'b0100, 2'd2, 3'h3, 16'hF0F0};
        tbl[11] = '{4'b1001, 2'd3, 3'h4, 16'hC001};
        tbl[12] = '{4'b1001, 2'd0, 3'h5, 16'h3C3C};

        bus.req = '0;
        bus.req_addr = '0;
        bus.req_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_ena", 32'(bus.ser_ena), 0);
        chk("rst_addr", 32'(bus.ser_addr), 0);
        chk("rst_data", 32'(bus.ser_data), 0);
        chk("rst_gid", 32'(bus.grant_id), 0);
        chk("rst_active", 32'(bus.active), 0);
        chk("rst_err", 32'(bus.err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table: single, fairness, wrap; winner slot holds the row's word.
        foreach (tbl[r]) begin
            for (int i = 0; i < 4; i++)
                set_slot(i, tbl[r].addr ^ 3'(i ^ int'(tbl[r].gid)),
                         tbl[r].data ^ (16'(i ^ int'(tbl[r].gid)) * 16'h1111));
            xfer(tbl[r].req, 3, g, a, d, k, lat, ak);
            chk($sformatf("tbl%0d_gid", r), 32'(g), 32'(tbl[r].gid));
            chk($sformatf("tbl%0d_addr", r), 32'(a), 32'(tbl[r].addr));
            chk($sformatf("tbl%0d_data", r), 32'(d), 32'(tbl[r].data));
            chk($sformatf("tbl%0d_ack", r), 32'(k), 32'(4'b1 << tbl[r].gid));
            chk($sformatf("tbl%0d_active", r), 32'(ak), 1);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("addr_hold", 32'(bus.ser_addr), 32'(tbl[12].addr));
        chk("idle_active", 32'(bus.active), 0);

        // Busy block: no start while the serializer reports busy.
        force_busy = 1'b1;
        bus.req = 4'b0001;
        flag = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ser_ena || bus.active) flag = 1'b1;
        end
        chk("busy_block", 32'(flag), 0);
        force_busy = 1'b0;
        xfer(4'b0001, 2, g, a, d, k, lat, ak);
        chk("busy_gid", 32'(g), 0);
        chk("busy_ack", 32'(k), 32'(4'b0001));

        // Reset mid-transfer.
        bus.req = 4'b0010;
        ser_len = 10;
        flag = 1'b0;
        for (int c = 0; c < 20 && !flag; c++) begin
            @(negedge clk);
            if (bus.ser_busy) flag = 1'b1;
        end
        chk("mid_busy_seen", 32'(flag), 1);
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        chk("mid_ack", 32'(bus.ack), 0);
        chk("mid_active", 32'(bus.active), 0);
        chk("mid_ena", 32'(bus.ser_ena), 0);
        chk("mid_gid", 32'(bus.grant_id), 0);
        rst = 1'b0;
        flag = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.ack != 0) flag = 1'b1;
        end
        chk("mid_no_ack", 32'(flag), 0);
        xfer(4'b1111, 3, g, a, d, k, lat, ak);
        chk("mid_ptr0", 32'(g), 0);
        xfer(4'b0100, 3, g, a, d, k, lat, ak);
        chk("mid_gid2", 32'(g), 2);
        chk("mid_ack2", 32'(k), 32'(4'b0100));
        bus.req = '0;

        // Randomized traffic against a round-robin reference.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        for (int it = 0; it < 40; it++) begin
            int len;
            mask = 4'($urandom_range(1, 15));
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < 4; i++) begin
                ra[i] = 3'($urandom);
                rd[i] = 16'($urandom);
                set_slot(i, ra[i], rd[i]);
            end
            w = -1;
            for (int s = 0; s < 4; s++)
                if (w < 0 && mask[(m_ptr + s) % 4]) w = (m_ptr + s) % 4;
            xfer(mask, len, g, a, d, k, lat, ak);
            chk($sformatf("rnd%0d_gid", it), 32'(g), 32'(w));
            chk($sformatf("rnd%0d_addr", it), 32'(a), 32'(ra[w]));
            chk($sformatf("rnd%0d_data", it), 32'(d), 32'(rd[w]));
            chk($sformatf("rnd%0d_ack", it), 32'(k), 32'(1 << w));
            chk($sformatf("rnd%0d_lat", it), 32'(lat), 32'(len + 2));
            chk($sformatf("rnd%0d_active", it), 32'(ak), 1);
            m_ptr = (w + 1) % 4;
        end
        bus.req = '0;
        repeat (2) @(negedge clk);

`ifdef SER_ARB_TIMEOUT_EN
        begin
            int t_ena, t_err;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            ser_stuck = 1'b1;
            bus.req = 4'b0001;
            t_ena = -1;
            t_err = -1;
            flag = 1'b0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (bus.ser_ena && t_ena < 0) begin
                    t_ena = c;
                    bus.req = '0;
                end
                if (bus.err && t_err < 0) t_err = c;
                if (bus.ack != 0) flag = 1'b1;
            end
            chk("to_ena_seen", 32'(t_ena >= 0), 1);
            chk("to_err_delay", 32'(t_err - t_ena), 5);
            chk("to_no_ack", 32'(flag), 0);
            chk("to_active", 32'(bus.active), 0);
            ser_stuck = 1'b0;
            xfer(4'b0011, 3, g, a, d, k, lat, ak);
            chk("to_next_gid", 32'(g), 1);
            chk("to_next_ack", 32'(k), 32'(4'b0010));
            chk("to_err_sticky", 32'(bus.err), 1);
            bus.req = '0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
